lm32_tlb_refill: RTL

Hardware page-table walker serving the LM32 instruction TLB. On a TLB miss it reads page-table entries from memory over a dedicated Wishbone master port and writes the resulting translation into the TLB through the vaddr/paddr update path. Faults and bus errors are reported to the exception logic. It sits between the ITLB miss output and the shared memory arbiter.

---
 rtl/lm32_tlb_refill.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lm32_tlb_refill.sv
// Hardware page-table walker refilling the LM32 instruction TLB over a private Wishbone read port.
// Define CFG_TLB_REFILL_TWO_LEVEL_EN for a directory + leaf walk; otherwise a single linear table is used.
module lm32_tlb_refill #(
   parameter int page_size     = 4096,
   parameter int pte_valid_bit = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ptbr_i,
   input  logic        miss_i,
   input  logic [31:0] miss_vaddr_i,
   input  logic        abort_i,
   output logic        busy_o,
   output logic        tlb_upd_o,
   output logic [31:0] tlb_vaddr_o,
   output logic [31:0] tlb_paddr_o,
   output logic        fault_o,
   output logic [31:0] fault_vaddr_o,
   output logic [31:0] pt_adr_o,
   output logic        pt_cyc_o,
   output logic        pt_stb_o,
   input  logic [31:0] pt_dat_i,
   input  logic        pt_ack_i,
   input  logic        pt_err_i
);

   localparam int OFS = $clog2(page_size);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
`ifdef CFG_TLB_REFILL_TWO_LEVEL_EN
      L1     = 3'd1,
`endif
      L2     = 3'd2,
      UPDATE = 3'd3,
      FAULT  = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [31:0]       va;
   logic [31:OFS]     pte_page;
   logic [31:OFS]     tlb_va_page;
   logic [31:0]       l2_adr;
   logic              entry_valid;
   logic              unused_bits;

   function automatic logic [31:0] page_base(input logic [31:0] a);
      return {a[31:OFS], {OFS{1'b0}}};
   endfunction

   assign entry_valid = pt_dat_i[pte_valid_bit];
   assign unused_bits = ^{ptbr_i[OFS-1:0], pt_dat_i[OFS-1:0]};

`ifdef CFG_TLB_REFILL_TWO_LEVEL_EN
   logic [31:OFS]     dir_page;
   logic [31:0]       l1_adr;
   assign l1_adr = page_base(ptbr_i) + (32'(va[31:OFS+10]) << 2);
   assign l2_adr = {dir_page, {OFS{1'b0}}} + (32'(va[OFS+9:OFS]) << 2);
`else
   // Linear table: one word per virtual page, indexed straight off the PTBR.
   assign l2_adr = page_base(ptbr_i) + (32'(va[31:OFS]) << 2);
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         va          <= '0;
         pte_page    <= '0;
         tlb_va_page <= '0;
`ifdef CFG_TLB_REFILL_TWO_LEVEL_EN
         dir_page    <= '0;
`endif
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx != IDLE)
            va <= miss_vaddr_i;
`ifdef CFG_TLB_REFILL_TWO_LEVEL_EN
         if (state == L1 && state_nx == L2)
            dir_page <= pt_dat_i[31:OFS];
`endif
         // The TLB-facing address pair only moves on a successful leaf read.
         if (state == L2 && state_nx == UPDATE) begin
            pte_page    <= pt_dat_i[31:OFS];
            tlb_va_page <= va[31:OFS];
         end
      end
   end

   always_comb begin
      state_nx = state;
      pt_adr_o = '0;
      pt_cyc_o = 1'b0;
      case (state)
         IDLE: begin
            if (miss_i && !abort_i)
`ifdef CFG_TLB_REFILL_TWO_LEVEL_EN
               state_nx = L1;
`else
               state_nx = L2;
`endif
         end
`ifdef CFG_TLB_REFILL_TWO_LEVEL_EN
         L1: begin
            pt_adr_o = l1_adr;
            pt_cyc_o = 1'b1;
            if (abort_i)
               state_nx = IDLE;
            else if (pt_err_i)
               state_nx = FAULT;
            else if (pt_ack_i)
               state_nx = entry_valid ? L2 : FAULT;
         end
`endif
         L2: begin
            pt_adr_o = l2_adr;
            pt_cyc_o = 1'b1;
            // Abort beats a concurrent ack/err; err beats ack.
            if (abort_i)
               state_nx = IDLE;
            else if (pt_err_i)
               state_nx = FAULT;
            else if (pt_ack_i)
               state_nx = entry_valid ? UPDATE : FAULT;
         end
         UPDATE:  state_nx = IDLE;
         FAULT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign pt_stb_o      = pt_cyc_o;
   assign busy_o        = (state != IDLE);
   assign tlb_upd_o     = (state == UPDATE);
   assign fault_o       = (state == FAULT);
   assign tlb_vaddr_o   = {tlb_va_page, {OFS{1'b0}}};
   assign tlb_paddr_o   = {pte_page, {OFS{1'b0}}};
   assign fault_vaddr_o = va;

endmodule
